button_event_ctrl: RTL and testbench

BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

---
 rtl/button_event_ctrl.sv | 162 ++++++++++++++++
 tb/tb_button_event_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
// Per-button press/release/auto-repeat event generator. Each button has one pending slot, and a round-robin arbiter feeds a single output register.
// Auto-repeat timing is built only when the macro BTN_REPEAT_EN is defined.
module button_event_ctrl #(
  parameter int NUM_BTN    = 4,
  parameter int HOLD_CYC   = 25000000,
  parameter int REPEAT_CYC = 5000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BTN-1:0]         btn_db,
  input  logic                       evt_ready,
  input  logic                       ovf_clr,
  output logic                       evt_valid,
  output logic [$clog2(NUM_BTN)-1:0] evt_btn,
  output logic [1:0]                 evt_type,
  output logic                       evt_overflow
);

  localparam int IDX_W = $clog2(NUM_BTN);
  localparam int CW    = IDX_W + 1;
  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;

  typedef enum logic [1:0] {IDLE, PRESSED, REPEATING} state_t;

  logic [NUM_BTN-1:0] btn_q;
  state_t             state_r   [NUM_BTN];
  state_t             state_n   [NUM_BTN];
  logic [NUM_BTN-1:0] post;
  logic [1:0]         post_type [NUM_BTN];
  logic [NUM_BTN-1:0] slot_valid;
  logic [1:0]         slot_type [NUM_BTN];
  logic [NUM_BTN-1:0] lost;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [CW-1:0]      cand;
  logic               grant_any;
  logic               load;
  logic               take;

`ifdef BTN_REPEAT_EN
  localparam int MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC);
  localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYC - 1);
  localparam logic [1:0]       EVT_REPEAT  = 2'b11;

  logic [TMR_W-1:0] timer_r [NUM_BTN];
  logic [TMR_W-1:0] timer_n [NUM_BTN];
`endif

  // Release wins over a timer expiry landing in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_n[i]   = state_r[i];
      post[i]      = 1'b0;
      post_type[i] = 2'b00;
`ifdef BTN_REPEAT_EN
      timer_n[i]   = timer_r[i];
`endif
      case (state_r[i])
        IDLE: begin
          if (btn_db[i] && !btn_q[i]) begin
            state_n[i]   = PRESSED;
            post[i]      = 1'b1;
            post_type[i] = EVT_PRESS;
`ifdef BTN_REPEAT_EN
            timer_n[i]   = '0;
`endif
          end
        end
        PRESSED, REPEATING: begin
          if (!btn_db[i] && btn_q[i]) begin
            state_n[i]   = IDLE;
            post[i]      = 1'b1;
            post_type[i] = EVT_RELEASE;
`ifdef BTN_REPEAT_EN
            timer_n[i]   = '0;
          end else if ((state_r[i] == PRESSED   && timer_r[i] == HOLD_LAST) ||
                       (state_r[i] == REPEATING && timer_r[i] == REPEAT_LAST)) begin
            state_n[i]   = REPEATING;
            post[i]      = 1'b1;
            post_type[i] = EVT_REPEAT;
            timer_n[i]   = '0;
          end else begin
            timer_n[i]   = timer_r[i] + 1'b1;
`endif
          end
        end
        default: state_n[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_BTN)) cand = cand - CW'(NUM_BTN);
      if (!grant_any && slot_valid[cand[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign load = !evt_valid || evt_ready;
  assign take = load && grant_any;

  // A slot emptied by this cycle's grant accepts a new event without loss.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      lost[i] = post[i] && slot_valid[i] && !(take && grant_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q        <= '0;
      slot_valid   <= '0;
      rr_ptr       <= '0;
      evt_valid    <= 1'b0;
      evt_btn      <= '0;
      evt_type     <= 2'b00;
      evt_overflow <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_r[i]   <= IDLE;
        slot_type[i] <= 2'b00;
`ifdef BTN_REPEAT_EN
        timer_r[i]   <= '0;
`endif
      end
    end else begin
      btn_q <= btn_db;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_r[i] <= state_n[i];
`ifdef BTN_REPEAT_EN
        timer_r[i] <= timer_n[i];
`endif
        if (post[i]) begin
          slot_valid[i] <= 1'b1;
          slot_type[i]  <= post_type[i];
        end else if (take && grant_idx == IDX_W'(i)) begin
          slot_valid[i] <= 1'b0;
        end
      end
      if (take) begin
        evt_valid <= 1'b1;
        evt_btn   <= grant_idx;
        evt_type  <= slot_type[grant_idx];
        rr_ptr    <= (grant_idx == IDX_W'(NUM_BTN - 1)) ? '0 : grant_idx + 1'b1;
      end else if (load) begin
        evt_valid <= 1'b0;
      end
      if (|lost) evt_overflow <= 1'b1;
      else if (ovf_clr) evt_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl (NUM_BTN=4, HOLD_CYC=8, REPEAT_CYC=4).
// Repeat expectations follow BTN_REPEAT_EN, which must match the RTL build.
module tb_button_event_ctrl;

  localparam int NUM_BTN    = 4;
  localparam int HOLD_CYC   = 8;
  localparam int REPEAT_CYC = 4;
`ifdef BTN_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif
  localparam logic [1:0] PRESS   = 2'b01;
  localparam logic [1:0] RELEASE = 2'b10;
  localparam logic [1:0] REPEAT  = 2'b11;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_BTN-1:0] btn_db;
  logic               evt_ready;
  logic               ovf_clr;
  logic               evt_valid;
  logic [1:0]         evt_btn;
  logic [1:0]         evt_type;
  logic               evt_overflow;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .NUM_BTN   (NUM_BTN),
    .HOLD_CYC  (HOLD_CYC),
    .REPEAT_CYC(REPEAT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_db      (btn_db),
    .evt_ready   (evt_ready),
    .ovf_clr     (ovf_clr),
    .evt_valid   (evt_valid),
    .evt_btn     (evt_btn),
    .evt_type    (evt_type),
    .evt_overflow(evt_overflow)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [NUM_BTN-1:0] btn, input logic ready, input logic clr);
    btn_db    = btn;
    evt_ready = ready;
    ovf_clr   = clr;
  endtask

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic check_event(input string tag, input logic exp_valid, input logic [1:0] exp_btn,
                             input logic [1:0] exp_type);
    check_output({tag, ".valid"}, 8'(evt_valid), 8'(exp_valid));
    if (exp_valid) begin
      check_output({tag, ".btn"}, 8'(evt_btn), 8'(exp_btn));
      check_output({tag, ".type"}, 8'(evt_type), 8'(exp_type));
    end
  endtask

  initial begin
    logic       exp_v;
    logic [1:0] exp_t;

    rst = 1'b1;
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    tick(); tick();
    check_output("reset.valid", 8'(evt_valid), 8'd0);
    check_output("reset.btn", 8'(evt_btn), 8'd0);
    check_output("reset.type", 8'(evt_type), 8'd0);
    check_output("reset.ovf", 8'(evt_overflow), 8'd0);

    $display("[TB] simultaneous presses and round-robin");
    rst = 1'b0;
    apply_stimulus(4'b1001, 1'b1, 1'b0);
    tick(); check_event("rr.lat", 1'b0, 2'd0, PRESS);
    tick(); check_event("rr.p0", 1'b1, 2'd0, PRESS);
    tick(); check_event("rr.p3", 1'b1, 2'd3, PRESS);
    tick(); check_event("rr.idle1", 1'b0, 2'd0, PRESS);
    apply_stimulus(4'b1011, 1'b1, 1'b0);
    tick(); check_event("rr.lat1", 1'b0, 2'd0, PRESS);
    tick(); check_event("rr.p1", 1'b1, 2'd1, PRESS);
    apply_stimulus(4'b0010, 1'b1, 1'b0);
    tick(); check_event("rr.lat2", 1'b0, 2'd0, PRESS);
    tick(); check_event("rr.r3", 1'b1, 2'd3, RELEASE);
    tick(); check_event("rr.r0", 1'b1, 2'd0, RELEASE);
    tick(); check_event("rr.idle2", 1'b0, 2'd0, PRESS);
    apply_stimulus(4'b0000, 1'b1, 1'b0);
    tick();
    tick(); check_event("rr.r1", 1'b1, 2'd1, RELEASE);
    tick(); check_event("rr.idle3", 1'b0, 2'd0, PRESS);

    $display("[TB] post into slot being granted");
    apply_stimulus(4'b0100, 1'b1, 1'b0);
    tick();
    apply_stimulus(4'b0000, 1'b1, 1'b0);
    tick(); check_event("grant.p2", 1'b1, 2'd2, PRESS);
    check_output("grant.ovf", 8'(evt_overflow), 8'd0);
    tick(); check_event("grant.r2", 1'b1, 2'd2, RELEASE);
    tick(); check_event("grant.idle", 1'b0, 2'd0, PRESS);

    $display("[TB] backpressure without loss");
    apply_stimulus(4'b0010, 1'b0, 1'b0);
    tick();
    tick(); check_event("bp.p1", 1'b1, 2'd1, PRESS);
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    tick(); check_event("bp.hold1", 1'b1, 2'd1, PRESS);
    tick(); check_event("bp.hold2", 1'b1, 2'd1, PRESS);
    check_output("bp.ovf", 8'(evt_overflow), 8'd0);
    apply_stimulus(4'b0000, 1'b1, 1'b0);
    tick(); check_event("bp.r1", 1'b1, 2'd1, RELEASE);
    tick(); check_event("bp.idle", 1'b0, 2'd0, PRESS);
    check_output("bp.ovf_end", 8'(evt_overflow), 8'd0);

    $display("[TB] overflow and clear");
    apply_stimulus(4'b0010, 1'b0, 1'b0);
    tick();
    tick(); check_event("ovf.p1", 1'b1, 2'd1, PRESS);
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    tick(); check_output("ovf.none", 8'(evt_overflow), 8'd0);
    apply_stimulus(4'b0010, 1'b0, 1'b0);
    tick(); check_output("ovf.set", 8'(evt_overflow), 8'd1);
    check_event("ovf.held", 1'b1, 2'd1, PRESS);
    apply_stimulus(4'b0000, 1'b0, 1'b1);
    tick(); check_output("ovf.set_vs_clr", 8'(evt_overflow), 8'd1);
    apply_stimulus(4'b0000, 1'b0, 1'b1);
    tick(); check_output("ovf.cleared", 8'(evt_overflow), 8'd0);
    apply_stimulus(4'b0000, 1'b1, 1'b0);
    tick(); check_event("ovf.r1", 1'b1, 2'd1, RELEASE);
    tick(); check_event("ovf.idle", 1'b0, 2'd0, PRESS);

    $display("[TB] asynchronous reset with button held");
    apply_stimulus(4'b0001, 1'b0, 1'b0);
    tick();
    tick(); check_event("rst.p0", 1'b1, 2'd0, PRESS);
    apply_stimulus(4'b1001, 1'b0, 1'b0);
    tick();
    apply_stimulus(4'b0001, 1'b0, 1'b0);
    tick(); check_output("rst.ovf_before", 8'(evt_overflow), 8'd1);
    #2 rst = 1'b1;
    #1;
    check_output("rst.async_valid", 8'(evt_valid), 8'd0);
    check_output("rst.async_btn", 8'(evt_btn), 8'd0);
    check_output("rst.async_type", 8'(evt_type), 8'd0);
    check_output("rst.async_ovf", 8'(evt_overflow), 8'd0);
    tick();
    rst = 1'b0;
    apply_stimulus(4'b0001, 1'b1, 1'b0);
    for (int n = 1; n <= 53; n++) begin
      tick();
      exp_v = (n == 2) || (n == 52) ||
              (REPEAT_EN && n >= 10 && n <= 50 && ((n - 10) % REPEAT_CYC) == 0);
      exp_t = (n == 2) ? PRESS : (n == 52) ? RELEASE : REPEAT;
      check_event($sformatf("hold.n%0d", n), exp_v, 2'd0, exp_t);
      if (n == 50) apply_stimulus(4'b0000, 1'b1, 1'b0);
    end

`ifdef BTN_REPEAT_EN
    $display("[TB] release coinciding with hold expiry");
    apply_stimulus(4'b0100, 1'b1, 1'b0);
    for (int m = 1; m <= 12; m++) begin
      tick();
      exp_v = (m == 2) || (m == 10);
      exp_t = (m == 2) ? PRESS : RELEASE;
      check_event($sformatf("prio.m%0d", m), exp_v, 2'd2, exp_t);
      if (m == 8) apply_stimulus(4'b0000, 1'b1, 1'b0);
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
